// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the single register-file write port between the in-order
//            pipeline write-back stage and long-latency unit results
//            (mul/div, load-miss refill). The pipeline has priority. Long-unit
//            results wait in a DEPTH-entry FIFO and drain on idle pipeline
//            cycles. If the FIFO head goes ungranted for STARVE_LIMIT cycles,
//            a one-cycle pipeline stall is injected to force a drain.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i             in   1   clock, rising edge
//   rst_ni            in   1   asynchronous active-low reset
//   pipe_reg_write_i  in   1   pipeline write-back request
//   pipe_reg_i        in   5   pipeline destination register
//   pipe_data_i       in  64   pipeline write data
//   long_valid_i      in   1   long unit presents a result
//   long_ready_o      out  1   FIFO can accept (push = valid & ready)
//   long_reg_i        in   5   long-unit destination register
//   long_data_i       in  64   long-unit result
//   pipe_stall_o      out  1   holds pipeline write-back for one cycle
//   reg_write_out_o   out  1   register-file write enable (registered)
//   reg2write_o       out  5   register-file write address (registered)
//   data2write_o      out 64   register-file write data (registered)
//   pending_mask_o    out 32   registers with a write outstanding in FIFO
// Build option
//   WB_ARB_SCOREBOARD_EN : when defined, pending_mask_o is built; otherwise
//                          it is tied to zero.
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter bit XZR_DROP     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pipe_reg_write_i,
    input  logic [4:0]  pipe_reg_i,
    input  logic [63:0] pipe_data_i,
    input  logic        long_valid_i,
    output logic        long_ready_o,
    input  logic [4:0]  long_reg_i,
    input  logic [63:0] long_data_i,
    output logic        pipe_stall_o,
    output logic        reg_write_out_o,
    output logic [4:0]  reg2write_o,
    output logic [63:0] data2write_o,
    output logic [31:0] pending_mask_o
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUEUED = 2'd1,
        ST_STALL  = 2'd2
    } state_e;

    state_e              state_q;
    logic [STARVE_W-1:0] starve_cnt_q;

    logic [4:0]          mem_reg_q  [DEPTH];
    logic [63:0]         mem_data_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    logic                we_q;
    logic [4:0]          reg_q;
    logic [63:0]         data_q;

    logic                w_empty;
    logic                w_full;
    logic                w_stall;
    logic                w_push;
    logic                w_pop;
    logic                w_grant_pipe;
    logic [4:0]          w_gnt_reg;
    logic [63:0]         w_gnt_data;
    logic                w_write;

    // ------------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------------
    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_stall = (state_q == ST_STALL);

    // Fullness uses the registered count only, so a same-cycle pop never
    // frees a slot for a push.
    assign w_push = long_valid_i & ~w_full;

    // The FIFO drains when the pipeline is idle, or unconditionally while
    // the starvation stall holds the pipeline off.
    assign w_pop        = ~w_empty & (w_stall | ~pipe_reg_write_i);
    assign w_grant_pipe = pipe_reg_write_i & ~w_pop;

    assign w_gnt_reg  = w_pop ? mem_reg_q[rd_ptr_q]  : pipe_reg_i;
    assign w_gnt_data = w_pop ? mem_data_q[rd_ptr_q] : pipe_data_i;

    // A grant to XZR is consumed (including its pop) but never written.
    assign w_write = (w_pop | w_grant_pipe) &
                     ~(XZR_DROP && (w_gnt_reg == 5'd31));

    assign count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_reg_q[wr_ptr_q]  <= long_reg_i;
            mem_data_q[wr_ptr_q] <= long_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Starvation FSM: IDLE (empty), QUEUED (counting), STALL (forced drain)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    starve_cnt_q <= '0;
                    state_q      <= w_push ? ST_QUEUED : ST_IDLE;
                end
                ST_QUEUED, ST_STALL: begin
                    if (w_pop || w_empty) begin
                        starve_cnt_q <= '0;
                        state_q      <= (count_d == '0) ? ST_IDLE : ST_QUEUED;
                    end else if (starve_cnt_q == STARVE_W'(STARVE_LIMIT)) begin
                        starve_cnt_q <= '0;
                        state_q      <= ST_STALL;
                    end else begin
                        starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
                        state_q      <= ST_QUEUED;
                    end
                end
                default: begin
                    starve_cnt_q <= '0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port; address/data hold when nothing is written
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            we_q <= w_write;
            if (w_write) begin
                reg_q  <= w_gnt_reg;
                data_q <= w_gnt_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------------
`ifdef WB_ARB_SCOREBOARD_EN
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [31:0]      mask_q;
    logic [31:0]      mask_d;
    logic [4:0]       w_slot_reg;

    // Mask reflects the FIFO contents after this cycle's push and pop, so
    // the entry being granted is already excluded. The push slot is always
    // distinct from the pop slot because a full FIFO cannot accept.
    always_comb begin
        valid_d    = valid_q;
        mask_d     = '0;
        w_slot_reg = '0;
        if (w_pop)  valid_d[rd_ptr_q] = 1'b0;
        if (w_push) valid_d[wr_ptr_q] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_reg = (w_push && (wr_ptr_q == PTR_W'(i))) ? long_reg_i
                                                              : mem_reg_q[i];
            if (valid_d[i]) mask_d[w_slot_reg] = 1'b1;
        end
        if (XZR_DROP) mask_d[31] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            mask_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mask_q  <= mask_d;
        end
    end

    assign pending_mask_o = mask_q;
`else
    assign pending_mask_o = 32'h0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Ready is forced low while reset is asserted so all outputs read zero.
    assign long_ready_o    = rst_ni & ~w_full;
    assign pipe_stall_o    = w_stall;
    assign reg_write_out_o = we_q;
    assign reg2write_o     = reg_q;
    assign data2write_o    = data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter: table-driven pipeline
//            vectors, directed multi-cycle sequences and a randomized run
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

`ifdef WB_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        pwe;
    logic [4:0]  preg;
    logic [63:0] pdata;
    logic        lv;
    logic        lready;
    logic [4:0]  lreg;
    logic [63:0] ldata;
    logic        stall;
    logic        we;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic [31:0] pmask;

    int n_tests = 0;
    int n_fail  = 0;

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT),
        .XZR_DROP     (1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pipe_reg_write_i (pwe),
        .pipe_reg_i       (preg),
        .pipe_data_i      (pdata),
        .long_valid_i     (lv),
        .long_ready_o     (lready),
        .long_reg_i       (lreg),
        .long_data_i      (ldata),
        .pipe_stall_o     (stall),
        .reg_write_out_o  (we),
        .reg2write_o      (wreg),
        .data2write_o     (wdata),
        .pending_mask_o   (pmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: a result queue plus a wait counter for its head
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  r;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_stall;
    int          m_wait;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [63:0] m_data;
    logic [4:0]  wlog[$];

    function automatic void model_reset();
        mq.delete();
        m_stall = 1'b0;
        m_wait  = 0;
        m_we    = 1'b0;
        m_reg   = '0;
        m_data  = '0;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].r] = 1'b1;
        m[31] = 1'b0;
        return SB_EN ? m : 32'h0;
    endfunction

    // One clock edge with the inputs currently driven.
    function automatic void model_edge();
        bit          had = (mq.size() != 0);
        bit          take_fifo = had && (m_stall || !pwe);
        bit          take_pipe = pwe && !take_fifo;
        bit          accept = lv && (mq.size() < DEPTH);
        ent_t        g;
        bit          next_stall = 1'b0;
        g.r = preg;
        g.d = pdata;
        if (take_fifo) g = mq.pop_front();
        if ((take_fifo || take_pipe) && g.r != 5'd31) begin
            m_we   = 1'b1;
            m_reg  = g.r;
            m_data = g.d;
        end else begin
            m_we = 1'b0;
        end
        if (take_fifo || !had) begin
            m_wait = 0;
        end else if (m_wait == STARVE_LIMIT) begin
            next_stall = 1'b1;
            m_wait     = 0;
        end else begin
            m_wait = m_wait + 1;
        end
        m_stall = next_stall;
        if (accept) mq.push_back('{r: lreg, d: ldata});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("we",    64'(we),     64'(m_we));
        check("reg",   64'(wreg),   64'(m_reg));
        check("data",  wdata,       m_data);
        check("stall", 64'(stall),  64'(m_stall));
        check("ready", 64'(lready), 64'(mq.size() < DEPTH));
        check("mask",  64'(pmask),  64'(model_mask()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (we) wlog.push_back(wreg);
        compare_model();
    endtask

    task automatic do_reset();
        pwe = 1'b0; preg = '0; pdata = '0;
        lv  = 1'b0; lreg = '0; ldata = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        pwe;
        logic [4:0]  preg;
        logic [63:0] pdata;
        logic        ewe;
        logic [4:0]  ereg;
        logic [63:0] edata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int edges;
        bit found;
        int stalls_seen;

        vecs[0] = '{1'b1, 5'd5,  64'hDEAD,                1'b1, 5'd5,  64'hDEAD};
        vecs[1] = '{1'b1, 5'd31, 64'h1,                   1'b0, 5'd5,  64'hDEAD};
        vecs[2] = '{1'b1, 5'd0,  64'h1234,                1'b1, 5'd0,  64'h1234};
        vecs[3] = '{1'b0, 5'd9,  64'hFFFF,                1'b0, 5'd0,  64'h1234};
        vecs[4] = '{1'b1, 5'd30, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 5'd30, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[5] = '{1'b0, 5'd31, 64'h0,                   1'b0, 5'd30, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[6] = '{1'b1, 5'd1,  64'h0,                   1'b1, 5'd1,  64'h0};
        vecs[7] = '{1'b1, 5'd31, 64'h7777,                1'b0, 5'd1,  64'h0};

        // ---------------- Reset state ----------------
        pwe = 1'b0; preg = '0; pdata = '0; lv = 1'b0; lreg = '0; ldata = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",    64'(we),     64'd0);
        check("rst_reg",   64'(wreg),   64'd0);
        check("rst_data",  wdata,       64'd0);
        check("rst_stall", 64'(stall),  64'd0);
        check("rst_mask",  64'(pmask),  64'd0);
        check("rst_ready", 64'(lready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 64'(lready), 64'd1);

        // ---------------- Table: pipeline writes, FIFO empty ----------------
        foreach (vecs[i]) begin
            pwe = vecs[i].pwe; preg = vecs[i].preg; pdata = vecs[i].pdata;
            step();
            check($sformatf("vec%0d_we", i),   64'(we),   64'(vecs[i].ewe));
            check($sformatf("vec%0d_reg", i),  64'(wreg), 64'(vecs[i].ereg));
            check($sformatf("vec%0d_data", i), wdata,     vecs[i].edata);
        end

        // ---------------- Starvation stall with a busy pipeline ----------------
        do_reset();
        pwe = 1'b1; preg = 5'd3; pdata = 64'h33;
        for (int i = 1; i <= 4; i++) begin
            lv = 1'b1; lreg = 5'(i); ldata = 64'(100 + i);
            step();
        end
        lv = 1'b0;
        check("starve_full_ready", 64'(lready), 64'd0);
        edges = 4;
        found = 1'b0;
        while (edges < 40 && !found) begin
            step();
            edges++;
            if (stall) found = 1'b1;
        end
        check("starve_stall_seen", 64'(found), 64'd1);
        check("starve_stall_edge", 64'(edges), 64'd10);
        step();
        check("starve_pulse_len", 64'(stall), 64'd0);
        check("starve_wr_we",     64'(we),    64'd1);
        check("starve_wr_reg",    64'(wreg),  64'd1);
        check("starve_wr_data",   wdata,      64'd101);

        // ---------------- Drain of two queued results ----------------
        do_reset();
        pwe = 1'b1; preg = 5'd2; pdata = 64'h22;
        lv = 1'b1; lreg = 5'd7; ldata = 64'h70; step();
        lreg = 5'd9; ldata = 64'h90; step();
        lv = 1'b0; pwe = 1'b0;
        step();
        check("drain_a_reg",   64'(wreg),   64'd7);
        check("drain_a_we",    64'(we),     64'd1);
        check("drain_a_ready", 64'(lready), 64'd1);
        step();
        check("drain_b_reg",   64'(wreg),   64'd9);
        check("drain_b_we",    64'(we),     64'd1);
        check("drain_b_ready", 64'(lready), 64'd1);
        step();
        check("drain_done_we", 64'(we),     64'd0);

        // ---------------- Full FIFO with same-cycle pop ----------------
        do_reset();
        pwe = 1'b1; preg = 5'd3; pdata = 64'h33;
        for (int i = 1; i <= 4; i++) begin
            lv = 1'b1; lreg = 5'(i); ldata = 64'(200 + i);
            step();
        end
        pwe = 1'b0; lv = 1'b1; lreg = 5'd20; ldata = 64'h2020;
        wlog.delete();
        #1;
        check("full_pop_ready", 64'(lready), 64'd0);
        step();
        check("full_after_pop_ready", 64'(lready), 64'd1);
        step();
        lv = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("full_wr_count", 64'(wlog.size()), 64'd5);
        if (wlog.size() == 5) begin
            for (int i = 0; i < 4; i++) check($sformatf("full_wr%0d", i), 64'(wlog[i]), 64'(i + 1));
            check("full_wr4", 64'(wlog[4]), 64'd20);
        end

        // ---------------- Async reset with queued results ----------------
        do_reset();
        pwe = 1'b1; preg = 5'd2; pdata = 64'h22;
        for (int i = 0; i < 3; i++) begin
            lv = 1'b1; lreg = 5'(12 + i); ldata = 64'(300 + i);
            step();
        end
        lv = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_we",    64'(we),     64'd0);
        check("arst_reg",   64'(wreg),   64'd0);
        check("arst_data",  wdata,       64'd0);
        check("arst_stall", 64'(stall),  64'd0);
        check("arst_mask",  64'(pmask),  64'd0);
        check("arst_ready", 64'(lready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pwe = 1'b0;
        wlog.delete();
        for (int i = 0; i < 4; i++) step();
        check("arst_no_stale_wr", 64'(wlog.size()), 64'd0);

        // Scoreboard bit for reg 12 set on push, cleared on grant
        pwe = 1'b1; preg = 5'd2; lv = 1'b1; lreg = 5'd12; ldata = 64'hC;
        step();
        lv = 1'b0;
        check("sb_set",   64'(pmask), SB_EN ? 64'h1000 : 64'h0);
        pwe = 1'b0;
        step();
        check("sb_clear", 64'(pmask), 64'h0);
        check("sb_wr",    64'(wreg),  64'd12);

        // ---------------- Randomized run against the model ----------------
        do_reset();
        stalls_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            if (((c / 150) % 2) == 1) pwe = ($urandom_range(0, 19) != 0);
            else                      pwe = ($urandom_range(0, 9) < 6);
            preg  = 5'($urandom_range(0, 31));
            pdata = {$urandom, $urandom};
            lv    = 1'($urandom_range(0, 1));
            lreg  = 5'($urandom_range(0, 31));
            ldata = {$urandom, $urandom};
            step();
            if (stall) stalls_seen++;
        end
        check("rand_stall_seen", 64'(stalls_seen > 0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
